fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the main control unit (UC).
- Holds the program counter and drives the instruction-memory address.
- Latches the fetched word into an IF/ID register and presents its OpCode field to UC.
- Resolves next-PC from UC's Branch/Jump outputs and the ALU Zero flag, and flushes the wrongly fetched instruction on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, word inserted into IF/ID on reset and flush.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hold PC and IF/ID contents this cycle.
Branch  in  1  from UC; instruction in IF/ID is BEQ.
Jump  in  1  from UC; instruction in IF/ID is J.
Zero  in  1  ALU equality flag for the instruction in IF/ID.
imem_addr  out  32  instruction-memory address; equals PC.
imem_data  in  32  instruction word at imem_addr; combinational read, same cycle.
instr_id  out  32  IF/ID instruction register.
pc_plus4_id  out  32  IF/ID copy of (fetch PC + 4).
OpCode  out  6  instr_id[31:26]; feeds UC.
valid_id  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset, asynchronous and active-high; while asserted:
  - PC = RESET_PC
  - instr_id = NOP_WORD
  - pc_plus4_id = 0
  - valid_id = 0
- imem_addr = PC, combinational. OpCode = instr_id[31:26], combinational.
- Derived values, all mod 2^32 (wrap, no overflow flag):
  - seq_pc = PC + 4
  - br_target = pc_plus4_id + (sign_extend(instr_id[15:0]) << 2)
  - j_target = {pc_plus4_id[31:28], instr_id[25:0], 2'b00}
- take_jump = valid_id & Jump. take_branch = valid_id & Branch & Zero & ~Jump.
- Per rising edge, first matching rule wins:
  1. stall = 1: PC, instr_id, pc_plus4_id and valid_id all hold. Redirects are ignored this cycle and re-evaluated next cycle, because the IF/ID instruction is still present.
  2. take_jump: PC <= j_target; instr_id <= NOP_WORD; valid_id <= 0; pc_plus4_id <= 0.
  3. take_branch: PC <= br_target; same flush as rule 2.
  4. otherwise: PC <= seq_pc; instr_id <= imem_data; pc_plus4_id <= seq_pc; valid_id <= 1.
- Branch with Zero = 0 is not taken and advances as rule 4.
- Jump and Branch both high: Jump wins. UC never produces this, but the behaviour is defined.
- Branch/Jump arriving while valid_id = 0 (bubble) are ignored, so no redirect comes from a flushed slot.
- Latency:
  - Fetch-to-IF/ID is 1 cycle.
  - Redirect penalty is exactly 1 bubble cycle: the target instruction appears in instr_id 2 edges after the redirect decision edge... strictly, the target is fetched in the cycle after the redirect edge and latched on the following edge.
- PC wrap: PC = 32'hFFFF_FFFC advances to 32'h0000_0000.
- Reset asserted mid-operation returns all state to reset values immediately, with no clock edge required. The first edge after deassertion latches imem_data at RESET_PC with valid_id = 1, unless stall is high on that edge.
- No internal memory; imem_data is trusted as returned.

Test Plan:
1. Reset then free run, imem returns addr-based words → after edge 1: instr_id = word@0x0, pc_plus4_id = 0x4, valid_id = 1, imem_addr = 0x4. After edge 3: imem_addr = 0xC.
2. Stall: raise stall for 2 cycles at PC = 0x8 → PC, instr_id and valid_id unchanged for both edges. On release, fetch resumes at 0x8 with no skipped or duplicated word.
3. Taken BEQ: instr_id = 0x1000_0003 (imm = 3), pc_plus4_id = 0x10, Branch = 1, Zero = 1 → next edge PC = 0x1C, valid_id = 0, instr_id = 0. Following edge instr_id = word@0x1C. Repeat with Zero = 0 → PC = PC+4, no flush. Repeat with imm = 0xFFFF → target = pc_plus4_id − 4.
4. Jump: instr_id = 0x0800_0040, pc_plus4_id = 0x3000_0010, Jump = 1 → PC = 0x3000_0100, one bubble. Jump and Branch both high with Zero = 1 → PC = j_target.
5. Redirect under stall/bubble: Jump = 1 with stall = 1 → no PC change; on release, redirect occurs. Jump = 1 with valid_id = 0 → ignored, PC+4.
6. Wrap and async reset: force PC to 0xFFFF_FFFC via branch target → next PC = 0x0. Pulse reset between clock edges → outputs reset immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Purpose : instruction-fetch stage ahead of the main control unit. Holds the
//             PC, drives the instruction-memory address, registers the fetched
//             word into IF/ID and resolves redirects from Branch/Jump/Zero.
//   Latency : fetch-to-IF/ID is one cycle. A taken redirect costs exactly one
//             bubble: the target is fetched the cycle after the redirect edge.
//   Stall   : stall freezes PC and the whole IF/ID register. Pending redirects
//             are re-evaluated once stall drops, since the IF/ID word is still
//             present.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   stall               hold PC and IF/ID this cycle
//   Branch, Jump, Zero  from UC / ALU, describing the instruction in IF/ID
//   imem_addr           instruction-memory address (= PC), combinational
//   imem_data           instruction word at imem_addr, same-cycle read
//   instr_id            IF/ID instruction register
//   pc_plus4_id         IF/ID copy of fetch PC + 4
//   OpCode              instr_id[31:26], feeds UC
//   valid_id            IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic [5:0]  OpCode,
    output logic        valid_id
);

    // Architectural state
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Next-state values
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;

    // Derived addresses (all arithmetic wraps mod 2^32)
    logic [31:0] w_seq_pc;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_take_jump;
    logic        w_take_branch;

    assign w_seq_pc    = r_pc + 32'd4;

    // Sign-extended word offset: imm16 sign-extended then shifted left by 2.
    assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_target = r_pc4 + w_br_offset;

    // Jump stays inside the 256 MB region of the delay-slot address.
    assign w_j_target  = {r_pc4[31:28], r_instr[25:0], 2'b00};

    // Redirects only come from a real instruction; a flushed slot can never
    // redirect even if UC's outputs are stale. Jump has priority over Branch.
    assign w_take_jump   = r_valid & Jump;
    assign w_take_branch = r_valid & Branch & Zero & ~Jump;

    always_comb begin
        // Default: hold everything (covers stall).
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;

        if (!stall) begin
            if (w_take_jump || w_take_branch) begin
                // The word fetched this cycle is on the wrong path: drop it and
                // insert a bubble while the target is fetched.
                w_pc_nxt    = w_take_jump ? w_j_target : w_br_target;
                w_instr_nxt = NOP_WORD;
                w_pc4_nxt   = 32'h0000_0000;
                w_valid_nxt = 1'b0;
            end else begin
                w_pc_nxt    = w_seq_pc;
                w_instr_nxt = imem_data;
                w_pc4_nxt   = w_seq_pc;
                w_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_WORD;
            r_pc4   <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign imem_addr   = r_pc;
    assign instr_id    = r_instr;
    assign pc_plus4_id = r_pc4;
    assign OpCode      = r_instr[31:26];
    assign valid_id    = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage: reset, free run, stall, taken/not-taken
//   BEQ, jump, redirect under stall and bubble, PC wrap, async reset.
//   The instruction memory is a combinational model in the bench.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic [5:0]  OpCode;
    logic        valid_id;

    int n_cmp;
    int n_err;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .Branch      (Branch),
        .Jump        (Jump),
        .Zero        (Zero),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr_id    (instr_id),
        .pc_plus4_id (pc_plus4_id),
        .OpCode      (OpCode),
        .valid_id    (valid_id)
    );

    // Memory contents: a few planted instructions, everything else is an
    // address-derived pattern so each fetch is identifiable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h1000_FFFD; // BEQ imm=-3
            32'h0000_000C: mem_word = 32'h1000_0003; // BEQ imm=+3
            32'h0000_0020: mem_word = 32'h1000_FFFF; // BEQ imm=-1
            32'h0000_0024: mem_word = 32'h1000_FFF4; // BEQ imm=-12
            32'hFFFF_FFF8: mem_word = 32'h0800_0040; // J
            default:       mem_word = a ^ 32'hC0DE_0000;
        endcase
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] pc4,
                           input logic v);
        chk({tag, ".pc"},     imem_addr,   pc);
        chk({tag, ".instr"},  instr_id,    ins);
        chk({tag, ".pc4"},    pc_plus4_id, pc4);
        chk({tag, ".valid"},  {31'd0, valid_id}, {31'd0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        stall  = 1'b0;
        Branch = 1'b0;
        Jump   = 1'b0;
        Zero   = 1'b0;

        // ---- Reset state ----
        #12;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.opcode", {26'd0, OpCode}, 32'h0);
        reset = 1'b0;

        // ---- Free run ----
        step();
        chk_all("run1", 32'h4, 32'h1000_FFFD, 32'h4, 1'b1);
        chk("run1.opcode", {26'd0, OpCode}, 32'h4);
        step();
        chk_all("run2", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);

        // ---- Stall two cycles at PC = 0x8 ----
        stall = 1'b1;
        step();
        chk_all("stall1", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
        step();
        chk_all("stall2", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
        stall = 1'b0;
        step();
        chk_all("resume", 32'hC, 32'hC0DE_0008, 32'hC, 1'b1);

        // ---- Taken BEQ, imm = +3 ----
        step();
        chk_all("beq_ld", 32'h10, 32'h1000_0003, 32'h10, 1'b1);
        Branch = 1'b1;
        Zero   = 1'b1;
        step();
        chk_all("beq_taken", 32'h1C, 32'h0, 32'h0, 1'b0);
        // Branch/Zero still high during the bubble: must be ignored.
        step();
        chk_all("beq_tgt", 32'h20, 32'hC0DE_001C, 32'h20, 1'b1);

        // ---- Not-taken BEQ (Zero = 0) ----
        Zero = 1'b0;
        step();
        chk_all("beq_nt", 32'h24, 32'h1000_FFFF, 32'h24, 1'b1);

        // ---- Taken BEQ, imm = 0xFFFF: target = pc_plus4_id - 4 ----
        Zero = 1'b1;
        step();
        chk_all("beq_neg", 32'h20, 32'h0, 32'h0, 1'b0);
        Branch = 1'b0;
        Zero   = 1'b0;
        step();
        chk_all("beq_neg_tgt", 32'h24, 32'h1000_FFFF, 32'h24, 1'b1);

        // ---- Branch backwards across zero to 0xFFFF_FFF8 ----
        step();
        chk_all("far_ld", 32'h28, 32'h1000_FFF4, 32'h28, 1'b1);
        Branch = 1'b1;
        Zero   = 1'b1;
        step();
        chk_all("far_br", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0);
        Branch = 1'b0;
        Zero   = 1'b0;
        step();
        chk_all("far_run", 32'hFFFF_FFFC, 32'h0800_0040, 32'hFFFF_FFFC, 1'b1);

        // ---- PC wrap ----
        step();
        chk_all("wrap", 32'h0, 32'h3F21_FFFC, 32'h0, 1'b1);
        step();
        chk_all("wrap_run", 32'h4, 32'h1000_FFFD, 32'h4, 1'b1);
        Branch = 1'b1;
        Zero   = 1'b1;
        step();
        chk_all("far_br2", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0);
        Branch = 1'b0;
        Zero   = 1'b0;
        step();
        chk_all("j_ld", 32'hFFFF_FFFC, 32'h0800_0040, 32'hFFFF_FFFC, 1'b1);
        chk("j_ld.opcode", {26'd0, OpCode}, 32'h2);

        // ---- Jump under stall: held, then redirect on release ----
        Jump  = 1'b1;
        stall = 1'b1;
        step();
        chk_all("j_stall", 32'hFFFF_FFFC, 32'h0800_0040, 32'hFFFF_FFFC, 1'b1);
        stall = 1'b0;
        step();
        chk_all("j_taken", 32'hF000_0100, 32'h0, 32'h0, 1'b0);

        // ---- Jump during bubble: ignored ----
        step();
        chk_all("j_bubble", 32'hF000_0104, 32'h30DE_0100, 32'hF000_0104, 1'b1);

        // ---- Jump and Branch together with Zero = 1: jump wins ----
        Branch = 1'b1;
        Zero   = 1'b1;
        step();
        chk_all("j_and_b", 32'hF378_0400, 32'h0, 32'h0, 1'b0);
        Jump   = 1'b0;
        Branch = 1'b0;
        Zero   = 1'b0;
        step();
        chk_all("j_and_b_tgt", 32'hF378_0404, 32'hF378_0400 ^ 32'hC0DE_0000,
                32'hF378_0404, 1'b1);

        // ---- Async reset between edges ----
        #2;
        reset = 1'b1;
        #1;
        chk_all("areset", 32'h0, 32'h0, 32'h0, 1'b0);
        stall = 1'b1;
        #1;
        reset = 1'b0;
        // First edge after reset with stall high: nothing latched.
        step();
        chk_all("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
        stall = 1'b0;
        step();
        chk_all("rst_run", 32'h4, 32'h1000_FFFD, 32'h4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
